dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter in front of the single-port, byte-addressed, big-endian data RAM. It shares the RAM between the CPU MEM-stage data port (port 0) and the debug/loader port (port 1). Each cycle it performs at most one word access. It resolves contention round-robin, and port 1 may hold a bounded locked burst. Read data is registered per port, and out-of-range or misaligned accesses are rejected. The block sits between the MEM-stage and loader logic on one side and the RAM on the other.

## Interface
Parameters:
- RAM_BYTES, 12288, RAM size in bytes; legal word addresses are 0 to RAM_BYTES-4.
- MAX_BURST, 4, maximum consecutive locked grants to port 1 while port 0 is waiting.

Ports (x = 0, 1):
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- reqx  input  1  access request; held high until ackx.
- wex  input  1  1 = write, 0 = read; stable while reqx is high.
- addrx  input  32  byte address of the word.
- wdatax  input  32  write data.
- lock1  input  1  port 1 burst lock request; port 1 only.
- ackx  output  1  access performed this cycle; combinational.
- errx  output  1  access rejected this cycle; asserted with ackx.
- rdatax  output  32  registered read data.
- rvalidx  output  1  rdatax updated this cycle; one-cycle pulse.
- stall0  output  1  reqx & ~ackx for port 0; feeds the CPU pipeline stall.
- MemWrite  output  1  RAM write enable.
- ramAddress  output  32  RAM byte address.
- ramStoreData  output  32  RAM write data.
- ramLoadData  input  32  RAM combinational read data.

## Operation
- The winner is chosen combinationally each cycle from req0, req1, lock1 and registered state.
- Registered state:
  - lastGrant (1 bit), reset value 1, so port 0 wins the first tie.
  - burstCnt (log2(MAX_BURST)+1 bits), reset value 0.
- Winner rules:
  - Only one port requesting: that port wins.
  - Both ports requesting, and port 1 is in a locked burst (lastGrant=1, lock1=1, burstCnt<MAX_BURST): port 1 wins.
  - Both ports requesting otherwise: the port that is not lastGrant wins.
  - No port requesting: no grant. ramAddress=0, ramStoreData=0, MemWrite=0, and all state holds.
- Grant effects:
  - ackx=1 for the winner.
  - ramAddress and ramStoreData are muxed from the winner.
  - lastGrant <= winner.
- burstCnt update:
  - burstCnt <= burstCnt+1 when port 1 wins while lock1=1.
  - burstCnt <= 0 when port 0 wins, or when port 1 wins with lock1=0.
  - burstCnt holds when idle.
  - burstCnt saturates at MAX_BURST.
  - burstCnt does not increment while port 0 is idle (locking only matters under contention).
- Legality check: an access is illegal when addrx[1:0] != 0 or addrx > RAM_BYTES-4.
  - Illegal access: the arbiter still grants it and asserts errx with ackx, but holds MemWrite=0.
  - An illegal read produces no rvalidx.
- Legal write: MemWrite=1 in the ack cycle; no rvalid.
- Legal read:
  - rdatax <= ramLoadData at the end of the ack cycle.
  - rvalidx=1 for the following cycle only.
  - rdatax holds between reads; the idle port's rdata is untouched.

## Timing
- Grant latency: 0 cycles. ackx is asserted in the same cycle that reqx is seen, if the port wins.
- Write commit: at the rising edge that ends the ack cycle.
- Read latency: rvalidx and rdatax are valid exactly 1 cycle after ackx.
- Back-to-back grants to the same port are allowed with no bubble. A read followed immediately by a read gives consecutive rvalid pulses.
- Contention with no lock: grants alternate 0,1,0,1.
- Worst-case wait for port 0: MAX_BURST+1 cycles.
- Reset (rst=0 at an edge): overrides everything, including mid-burst operation.
  - rdata0 and rdata1 = 0; rvalid0 and rvalid1 = 0; lastGrant=1; burstCnt=0.
  - A pending rvalid is dropped.
  - While rst=0, ackx, errx and MemWrite are forced to 0, and ramAddress and ramStoreData are forced to 0.
- Simultaneous read by one port and write by the other is impossible, since only one grant is issued per cycle.
- A read issued the cycle after a write to the same address returns the new data, because the RAM write commits at the edge.

## Test plan
- Reset:
  - Stimulus: hold rst=0 for 2 cycles with req0=req1=1.
  - Required response: no ack and MemWrite=0 during reset. On release, port 0 is granted first, then port 1.
- Write then read, port 0:
  - Stimulus: write 0x12345678 to 0x10, then read 0x10 the next cycle.
  - Required response: ack0 in both cycles, and MemWrite=1 only in the first. The cycle after the read has rvalid0=1 and rdata0=0x12345678.
- Contention:
  - Stimulus: req0 and req1 held high for 6 cycles, lock1=0.
  - Required response: ack sequence 0,1,0,1,0,1; stall0 high on alternate cycles.
- Locked burst, MAX_BURST=4:
  - Stimulus: port 1 wins with lock1=1 while req0 is held high.
  - Required response: ack1 for 4 consecutive cycles, then ack0 on cycle 5, then port 1 again.
- Errors:
  - Stimulus: write to 0x13, then read from 0x3000 (= RAM_BYTES).
  - Required response: ack and err pulse together each time, MemWrite stays 0, no rvalid, and the RAM contents are unchanged.
- Reset mid-read:
  - Stimulus: read acked in cycle N, and rst=0 at the edge ending cycle N.
  - Required response: rvalid never asserts, rdata=0, and lastGrant returns to its reset value of 1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// One requestor port of the data-RAM arbiter: request/write bus in, ack/error/read-data back.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, we, addr, wdata, input  ack, err, rdata, rvalid);
  modport slave  (input  req, we, addr, wdata, output ack, err, rdata, rvalid);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU MEM-stage port (p0) and the
// debug/loader port (p1): round-robin arbitration, bounded p1 lock bursts, registered read data.
module dmem_arbiter #(
  parameter int RAM_BYTES = 12288,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        p0,
  dmem_arbiter_if.slave        p1,
  input  logic                 lock1,
  output logic                 stall0,
  output logic                 MemWrite,
  output logic [31:0]          ramAddress,
  output logic [31:0]          ramStoreData,
  input  logic [31:0]          ramLoadData
);

  localparam int                 BURST_W   = $clog2(MAX_BURST) + 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [31:0]        ADDR_MAX  = 32'(RAM_BYTES - 4);

  logic               last_grant_q, last_grant_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic [31:0]        rdata0_q, rdata1_q;

  logic               locked;
  logic               grant0, grant1, any_grant;
  logic               win_we, win_legal;
  logic [31:0]        win_addr, win_wdata;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;

    // p1 keeps the RAM while it holds a lock and has burst budget left.
    locked = last_grant_q && lock1 && (burst_cnt_q < BURST_MAX);
    grant1 = rst && p1.req && (!p0.req || locked || !last_grant_q);
    grant0 = rst && p0.req && !grant1;
    any_grant = grant0 || grant1;

    if (grant0) begin
      win_addr  = p0.addr;
      win_wdata = p0.wdata;
      win_we    = p0.we;
    end else if (grant1) begin
      win_addr  = p1.addr;
      win_wdata = p1.wdata;
      win_we    = p1.we;
    end

    win_legal    = (win_addr[1:0] == 2'b00) && (win_addr <= ADDR_MAX);
    ramAddress   = win_addr;
    ramStoreData = win_wdata;
    MemWrite     = any_grant && win_we && win_legal;

    rvalid0_d = grant0 && !win_we && win_legal;
    rvalid1_d = grant1 && !win_we && win_legal;

    last_grant_d = any_grant ? grant1 : last_grant_q;

    // Burst budget only drains while p0 is actually waiting.
    burst_cnt_d = burst_cnt_q;
    if (grant0 || (grant1 && !lock1)) begin
      burst_cnt_d = '0;
    end else if (grant1 && p0.req && (burst_cnt_q < BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
  end

  assign p0.ack    = grant0;
  assign p1.ack    = grant1;
  assign p0.err    = grant0 && !win_legal;
  assign p1.err    = grant1 && !win_legal;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;
  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign stall0    = p0.req && !grant0;

  // NOTE: state uses non-blocking assignments; reset is synchronous and checked first so it wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      if (rvalid0_d) rdata0_q <= ramLoadData;
      if (rvalid1_d) rdata1_q <= ramLoadData;
    end
  end

endmodule
